card_deck_pool: RTL
===================

CARD_DECK_POOL -- requirements
Module: card_deck_pool

Interface
REQ-001 Parameters SHALL be: DEPTH, default 108, total card capacity; CARD_W, default 6, card code width; LFSR_W, default 16, shuffle LFSR width; MAX_DRAW, default 4, largest burst per draw request.
REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
- i_clk, in, 1, clock.
- i_rst_n, in, 1, reset: asynchronous, active-low.
- i_seed, in, LFSR_W, LFSR seed, sampled on i_shuffle.
- i_shuffle, in, 1, merge discard into draw pile and shuffle.
- i_put_valid, in, 1, put-card request.
- i_put_card, in, CARD_W, card returned to discard pile.
- o_put_ready, out, 1, put accepted when high with i_put_valid.
- i_draw_valid, in, 1, draw request.
- i_draw_cnt, in, $clog2(MAX_DRAW+1), number of cards to draw.
- o_draw_ready, out, 1, draw request accepted.
- o_card_valid, out, 1, one drawn card this cycle.
- o_card, out, CARD_W, drawn card.
- o_err, out, 1, one-cycle pulse on a rejected draw.
- o_busy, out, 1, state is not IDLE.
- o_draw_num, out, $clog2(DEPTH+1), draw-pile count.
- o_disc_num, out, $clog2(DEPTH+1), discard-pile count.

Function
REQ-003 Storage SHALL be one DEPTH-entry array; draw pile at indices [0, draw_num), top at draw_num-1; discard pile at [DEPTH-disc_num, DEPTH), growing downward.
REQ-004 FSM states SHALL be IDLE, REFILL, SHUFFLE, DRAW; o_busy = (state != IDLE).
REQ-005 o_put_ready SHALL be IDLE && !i_draw_valid && !i_shuffle && (draw_num+disc_num < DEPTH); an accepted put writes index DEPTH-1-disc_num and increments disc_num.
REQ-006 Priority in IDLE SHALL be i_shuffle > i_draw_valid > put.
REQ-007 i_shuffle in IDLE SHALL load LFSR with i_seed (1 if i_seed==0), then enter REFILL.
REQ-008 REFILL SHALL move one discard card per cycle to index draw_num (draw_num+1, disc_num-1) until disc_num==0, then enter SHUFFLE with i = draw_num-1.
REQ-009 SHUFFLE SHALL run Fisher-Yates: j = low $clog2(DEPTH) LFSR bits; if j>i, reject and step LFSR only; else swap [i],[j], decrement i, step LFSR; exit when i==0 or draw_num<=1.
REQ-010 LFSR SHALL be Fibonacci, shifted each SHUFFLE cycle, taps from package (LFSR_W=16: x^16+x^14+x^13+x^11+1).
REQ-011 Draw accept SHALL happen in IDLE when i_draw_valid && !i_shuffle; o_draw_ready pulses that cycle.
REQ-012 i_draw_cnt==0 or > MAX_DRAW or > draw_num+disc_num SHALL pulse o_err for one cycle, emit no cards, stay IDLE.
REQ-013 Otherwise remaining = i_draw_cnt, enter DRAW; each DRAW cycle with draw_num>0 SHALL pop top card into registered o_card with o_card_valid high next cycle, remaining-1.
REQ-014 DRAW with remaining>0 and draw_num==0 SHALL enter REFILL (LFSR not reseeded), then SHUFFLE, then return to DRAW.
REQ-015 DRAW with remaining==0 SHALL return to IDLE.
REQ-016 Latency SHALL be: draw accepted at cycle T yields first o_card_valid at T+2; cards consecutive absent refill.
REQ-017 o_card SHALL hold last drawn value while o_card_valid low; no output backpressure.
REQ-018 Counters SHALL be unsigned $clog2(DEPTH+1) bits; draw_num+disc_num never exceeds DEPTH; no wrap.
REQ-019 i_shuffle or i_draw_valid while busy SHALL be ignored, no error.

Reset
REQ-020 Reset assertion SHALL asynchronously force: state IDLE, draw_num=disc_num=0, LFSR=1, remaining=0, o_card=0, o_card_valid=0, o_err=0; array contents are don't-care.
REQ-021 Reset mid-DRAW/REFILL/SHUFFLE SHALL abort the operation, discard all cards, and emit no further o_card_valid.

Structure
REQ-022 Package card_deck_pkg SHALL hold the state enum, LFSR tap constants per LFSR_W, card colour/value encodings (colour 2b: red/yellow/green/blue; value 4b: 0-9, skip, reverse, draw-two, wild, wild-draw-four).
REQ-023 Sub-module card_lfsr SHALL implement the seedable, enable-stepped LFSR; all else lives in card_deck_pool.

Verification
REQ-024 DEPTH=8: put cards 0..7, i_shuffle seed 0x00A5 -> o_busy high, then draw_num=8, disc_num=0; multiset of the 8 cards unchanged; order matches golden model.
REQ-025 After REQ-024, draw cnt=4 at T -> o_card_valid at T+2..T+5, draw_num=4, o_busy low at T+6.
REQ-026 draw_num=2, disc_num=3, draw cnt=4 -> 2 cards, REFILL+SHUFFLE, 2 more; end with draw_num=1, disc_num=0.
REQ-027 draw cnt=5 with total 3, or cnt=0 -> o_err one cycle, no o_card_valid, counts unchanged.
REQ-028 Fill to 8 cards -> o_put_ready low; simultaneous put+draw in IDLE -> draw wins, put not accepted.
REQ-029 i_rst_n low during DRAW with 2 cards remaining -> o_card_valid 0 immediately, counts 0, state IDLE.

Source files
------------

// File: rtl/card_deck_pkg.sv
// Shared types and constants for the card deck pool.
// Holds FSM states, LFSR tap masks and card colour/value encodings.
package card_deck_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        SHUFFLE = 2'd2,
        DRAW    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        COL_RED    = 2'd0,
        COL_YELLOW = 2'd1,
        COL_GREEN  = 2'd2,
        COL_BLUE   = 2'd3
    } colour_t;

    localparam logic [3:0] VAL_SKIP  = 4'd10;
    localparam logic [3:0] VAL_REV   = 4'd11;
    localparam logic [3:0] VAL_DRAW2 = 4'd12;
    localparam logic [3:0] VAL_WILD  = 4'd13;
    localparam logic [3:0] VAL_WILD4 = 4'd14;

    // Fibonacci tap masks; bit k set means stage k+1 feeds the XOR.
    localparam logic [31:0] TAPS_8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_16 = 32'h0000_B400;
    localparam logic [31:0] TAPS_24 = 32'h00E1_0000;
    localparam logic [31:0] TAPS_32 = 32'hA300_0000;

    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            8:       return TAPS_8;
            24:      return TAPS_24;
            32:      return TAPS_32;
            default: return TAPS_16;
        endcase
    endfunction

    function automatic logic [5:0] make_card(input colour_t c,
                                             input logic [3:0] v);
        return {c, v};
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Seedable Fibonacci LFSR stepped by an enable.
// Ports: i_clk, i_rst_n, i_load/i_seed (seed, 0 maps to 1), i_en, o_rand.
module card_lfsr
    import card_deck_pkg::*;
#(
    parameter int W     = 16,
    parameter int OUT_W = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [W-1:0]     i_seed,
    input  logic             i_en,
    output logic [OUT_W-1:0] o_rand
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q <= W'(1);
        end else if (i_load) begin
            // An all-zero state would lock up the register.
            q <= (i_seed == '0) ? W'(1) : i_seed;
        end else if (i_en) begin
            q <= {q[W-2:0], ^(q & TAPS)};
        end
    end

    assign o_rand = q[OUT_W-1:0];

endmodule

// File: rtl/card_deck_pool.sv
// Card pool: draw pile and discard pile share one array; shuffle/draw FSM.
// Ports: put/draw handshakes, shuffle with seed, drawn card stream, counts.
module card_deck_pool
    import card_deck_pkg::*;
#(
    parameter int DEPTH    = 108,
    parameter int CARD_W   = 6,
    parameter int LFSR_W   = 16,
    parameter int MAX_DRAW = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [LFSR_W-1:0]            i_seed,
    input  logic                         i_shuffle,
    input  logic                         i_put_valid,
    input  logic [CARD_W-1:0]            i_put_card,
    output logic                         o_put_ready,
    input  logic                         i_draw_valid,
    input  logic [$clog2(MAX_DRAW+1)-1:0] i_draw_cnt,
    output logic                         o_draw_ready,
    output logic                         o_card_valid,
    output logic [CARD_W-1:0]            o_card,
    output logic                         o_err,
    output logic                         o_busy,
    output logic [$clog2(DEPTH+1)-1:0]   o_draw_num,
    output logic [$clog2(DEPTH+1)-1:0]   o_disc_num
);

    localparam int CW   = $clog2(MAX_DRAW+1);
    localparam int NW   = $clog2(DEPTH+1);
    localparam int IDXW = $clog2(DEPTH);

    state_t              state_q;
    logic [NW-1:0]       draw_num;
    logic [NW-1:0]       disc_num;
    logic [CW-1:0]       rem;
    logic [IDXW-1:0]     i_q;
    logic [IDXW-1:0]     j;
    logic [CARD_W-1:0]   mem [DEPTH];

    logic [NW:0]         total;
    logic                idle;
    logic                put_fire;
    logic                draw_bad;
    logic                seed_load;
    logic                shuf_end;
    logic                refill_mv;
    logic                swap_en;
    logic [IDXW-1:0]     put_idx;
    logic [IDXW-1:0]     disc_idx;
    logic [IDXW-1:0]     top_idx;

    assign total     = {1'b0, draw_num} + {1'b0, disc_num};
    assign idle      = (state_q == IDLE);
    assign o_busy    = !idle;
    assign o_put_ready = idle && !i_draw_valid && !i_shuffle
                       && (total < (NW+1)'(DEPTH));
    assign put_fire  = i_put_valid && o_put_ready;
    assign o_draw_ready = idle && i_draw_valid && !i_shuffle;
    assign draw_bad  = (i_draw_cnt == '0)
                     || (i_draw_cnt > CW'(MAX_DRAW))
                     || ((NW+1)'(i_draw_cnt) > total);
    assign seed_load = idle && i_shuffle;
    assign shuf_end  = (i_q == '0) || (draw_num <= NW'(1));
    assign refill_mv = (state_q == REFILL) && (disc_num != '0);
    // j beyond the unshuffled range is rejected, keeping the draw unbiased.
    assign swap_en   = (state_q == SHUFFLE) && !shuf_end && (j <= i_q);
    assign put_idx   = IDXW'(NW'(DEPTH-1) - disc_num);
    assign disc_idx  = IDXW'(NW'(DEPTH) - disc_num);
    assign top_idx   = IDXW'(draw_num - NW'(1));

    assign o_draw_num = draw_num;
    assign o_disc_num = disc_num;

    card_lfsr #(
        .W     (LFSR_W),
        .OUT_W (IDXW)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (seed_load),
        .i_seed  (i_seed),
        .i_en    (state_q == SHUFFLE),
        .o_rand  (j)
    );

    // Array contents need no reset; counters define what is valid.
    always_ff @(posedge i_clk) begin
        if (put_fire)
            mem[put_idx] <= i_put_card;
        if (refill_mv)
            mem[IDXW'(draw_num)] <= mem[disc_idx];
        if (swap_en) begin
            mem[i_q] <= mem[j];
            mem[j]   <= mem[i_q];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            draw_num     <= '0;
            disc_num     <= '0;
            rem          <= '0;
            i_q          <= '0;
            o_card       <= '0;
            o_card_valid <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_card_valid <= 1'b0;
            o_err        <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_shuffle) begin
                        state_q <= REFILL;
                    end else if (i_draw_valid) begin
                        if (draw_bad) begin
                            o_err <= 1'b1;
                        end else begin
                            rem     <= i_draw_cnt;
                            state_q <= DRAW;
                        end
                    end else if (put_fire) begin
                        disc_num <= disc_num + NW'(1);
                    end
                end
                REFILL: begin
                    if (disc_num != '0) begin
                        draw_num <= draw_num + NW'(1);
                        disc_num <= disc_num - NW'(1);
                    end else begin
                        state_q <= SHUFFLE;
                        i_q     <= top_idx;
                    end
                end
                SHUFFLE: begin
                    if (shuf_end)
                        state_q <= (rem != '0) ? DRAW : IDLE;
                    else if (swap_en)
                        i_q <= i_q - IDXW'(1);
                end
                DRAW: begin
                    if (rem == '0) begin
                        state_q <= IDLE;
                    end else if (draw_num != '0) begin
                        o_card       <= mem[top_idx];
                        o_card_valid <= 1'b1;
                        draw_num     <= draw_num - NW'(1);
                        rem          <= rem - CW'(1);
                    end else begin
                        // Draw pile ran dry mid-burst; LFSR keeps running.
                        state_q <= REFILL;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
